// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared sizing constants and register-index type for regfile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW       = 5;

  typedef logic [AW-1:0] reg_idx_t;
endpackage

`default_nettype wire

// File: rtl/regfile_rdport.sv
// ============================================================================
// Module      : regfile_rdport
// Description : One combinational read port; forces x0 to zero and, when
//               REGFILE_BYPASS_EN is defined, forwards same-cycle write data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic [AW-1:0]                addr_i,
  input  logic [NREG-1:0][XLEN-1:0]    regs_i,
  input  logic                         rst_i,
  input  logic                         we_i,
  input  logic [AW-1:0]                wr_addr_i,
  input  logic [XLEN-1:0]              wd_i,
  output logic [XLEN-1:0]              rdata_o
);

  always_comb begin
    rdata_o = '0;
    if ((addr_i != '0) && (int'(addr_i) < NREG)) begin
      rdata_o = regs_i[addr_i];
    end
`ifdef REGFILE_BYPASS_EN
    if (we_i && !rst_i && (wr_addr_i != '0) && (wr_addr_i == addr_i)) begin
      rdata_o = wd_i;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  // Write-port inputs only feed the forwarding path.
  logic w_unused_bypass;
  assign w_unused_bypass = &{1'b0, rst_i, we_i, wr_addr_i, wd_i};
`endif

endmodule

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// Module      : regfile
// Description : NREG x XLEN register file, one write port, two combinational
//               read ports, x0 hard-wired to zero. Optional write-to-read
//               forwarding selected by macro REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [NREG-1:0][XLEN-1:0] regs_q;
  logic [NREG-1:0][XLEN-1:0] regs_d;

  // Entry 0 is never written, so it stays at its reset value and is trimmed.
  always_comb begin
    regs_d = regs_q;
    if (we && (rd != '0) && (int'(rd) < NREG)) begin
      regs_d[rd] = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_rdport #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_rdport1 (
    .addr_i    (rs1),
    .regs_i    (regs_q),
    .rst_i     (rst),
    .we_i      (we),
    .wr_addr_i (rd),
    .wd_i      (wd),
    .rdata_o   (rd1)
  );

  regfile_rdport #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_rdport2 (
    .addr_i    (rs2),
    .regs_i    (regs_q),
    .rst_i     (rst),
    .we_i      (we),
    .wr_addr_i (rd),
    .wd_i      (wd),
    .rdata_o   (rd2)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
// Module      : tb_regfile
// Description : Scoreboard bench for regfile: directed cases plus random
//               traffic checked against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic [31:0] rd1;
  logic [31:0] rd2;

  regfile #(
    .XLEN (32),
    .NREG (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .we  (we),
    .rs1 (rs1),
    .rs2 (rs2),
    .rd  (rd),
    .wd  (wd),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem[32];
  int          total = 0;
  int          bad   = 0;

  // Architectural view: x0 is zero, optional forwarding of the pending write.
  function automatic logic [31:0] model_read(input int a, input logic bwe,
                                             input int brd, input logic [31:0] bwd,
                                             input logic brst);
    if (a == 0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (bwe && !brst && brd != 0 && brd == a) return bwd;
`endif
    return mem[a];
  endfunction

  task automatic step(input logic t_rst, input logic t_we, input logic [4:0] t_rd,
                      input logic [31:0] t_wd, input logic [4:0] t_rs1,
                      input logic [4:0] t_rs2, input bit chk, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = t_rst;
    we  = t_we;
    rd  = t_rd;
    wd  = t_wd;
    rs1 = t_rs1;
    rs2 = t_rs2;
    if (chk) begin
      e.tag = tag;
      e.e1  = model_read(int'(t_rs1), t_we, int'(t_rd), t_wd, t_rst);
      e.e2  = model_read(int'(t_rs2), t_we, int'(t_rd), t_wd, t_rst);
      sb_q.push_back(e);
    end
    if (t_rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    end else if (t_we === 1'b1 && t_rd !== 5'd0) begin
      mem[t_rd] = t_wd;
    end
  endtask

  // Monitor: reads are combinational, so the response is valid mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      total++;
      if (rd1 !== e.e1 || rd2 !== e.e2) begin
        bad++;
        $display("FAIL %s: rd1=%h rd2=%h, expected rd1=%h rd2=%h",
                 e.tag, rd1, rd2, e.e1, e.e2);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  r_rd;
    logic [4:0]  r_a;
    logic [4:0]  r_b;
    logic [31:0] r_wd;
    logic        r_we;
    logic        r_rst;
    int          drain;

    rst = 1'b0; we = 1'b0; rd = '0; wd = '0; rs1 = '0; rs2 = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;

    step(0, 0, 0, 0, 0, 0, 1, "x0_prereset");
    step(1, 0, 0, 0, 0, 0, 0, "");
    step(0, 0, 0, 0, 5'd7, 5'd31, 1, "reset_state");

    step(0, 1, 5'd1, 32'd10, 0, 0, 0, "");
    step(0, 0, 0, 0, 0, 0, 0, "");
    step(0, 1, 5'd2, 32'd20, 0, 0, 0, "");
    step(0, 0, 0, 0, 5'd1, 5'd2, 1, "basic_rw");

    step(0, 1, 5'd0, 32'd99, 5'd0, 5'd0, 1, "x0_write_cycle");
    step(0, 0, 0, 0, 5'd0, 5'd0, 1, "x0_protect");

    step(0, 0, 5'd3, 32'hDEADBEEF, 0, 0, 0, "");
    step(0, 0, 0, 0, 5'd3, 5'd1, 1, "we_gating");

    step(0, 1, 5'd5, 32'h1234, 0, 0, 0, "");
    step(0, 0, 0, 0, 5'd5, 5'd5, 1, "x5_written");
    step(1, 1, 5'd6, 32'd7, 0, 0, 0, "");
    step(0, 0, 0, 0, 5'd5, 5'd6, 1, "reset_priority");

    step(0, 1, 5'd4, 32'd1, 0, 0, 0, "");
    step(0, 1, 5'd4, 32'd2, 5'd4, 5'd4, 1, "rdw_before_edge");
    step(0, 0, 0, 0, 5'd4, 5'd1, 1, "rdw_after_edge");

    step(0, 0, 5'bxxxxx, 32'hxxxxxxxx, 5'bxxxxx, 5'bxxxxx, 0, "");
    step(0, 0, 0, 0, 5'd4, 5'd2, 1, "x_addr_no_effect");

    for (int i = 1; i < 32; i++) begin
      step(0, 1, 5'(i), 32'(i * 3 + 1), 0, 0, 0, "");
    end
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, "sweep");
    end

    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(0, 39) == 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_rd  = 5'($urandom_range(0, 31));
      r_wd  = $urandom;
      r_a   = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
      r_b   = ($urandom_range(0, 3) == 0) ? r_a  : 5'($urandom_range(0, 31));
      step(r_rst, r_we, r_rd, r_wd, r_a, r_b, 1, "random");
    end

    step(0, 0, 0, 0, 0, 0, 0, "");
    drain = 0;
    while (sb_q.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    if (sb_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
